// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE,
    FAIL
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Default timing at a 50 MHz system clock
  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_REQ_CYCLES     = 250;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd number of ones
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop synchronizer with registered falling-edge strobe
module ps2_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic fall_q;

  // Idle-high reset values so a released line never produces a spurious edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fall_q <= prev_q & ~sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int REQ_CYCLES     = DEF_REQ_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW     = $clog2(PH_MAX);
  localparam int TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] INH_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST = PW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e state_q;
  logic [7:0]    data_q;
  logic          parity_q;
  logic [PW-1:0] phase_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    bit_q;
  logic          clk_oe_q;
  logic          dat_oe_q;
  logic          done_q;
  logic          error_q;
  logic [1:0]    err_code_q;
  logic          dat_meta_q;
  logic          dat_sync_q;
  logic          clk_sync;
  logic          clk_fall;

  ps2_sync_edge u_clk_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (resetn),
    .pin_i  (ps2_clk_in),
    .sync_o (clk_sync),
    .fall_o (clk_fall)
  );

  // PS2_DAT only needs its level, so it gets the bare two-flop synchronizer
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Frame sequencer: inhibit, request-to-send, clocked shift, ACK and release
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      phase_q    <= '0;
      tmo_q      <= '0;
      bit_q      <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            data_q     <= cmd_data;
            parity_q   <= odd_parity(cmd_data);
            phase_q    <= '0;
            err_code_q <= ERR_NONE;
            clk_oe_q   <= 1'b1;
            state_q    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (phase_q == INH_LAST) begin
            phase_q  <= '0;
            dat_oe_q <= 1'b1;
            state_q  <= REQ;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        REQ: begin
          tmo_q <= '0;
          bit_q <= '0;
          if (phase_q == REQ_LAST) begin
            clk_oe_q <= 1'b0;
            state_q  <= SHIFT;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        SHIFT: begin
          if (tmo_q == TMO_LAST) begin
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= FAIL;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (clk_fall) begin
              if (bit_q < 4'd8) begin
                dat_oe_q <= ~data_q[bit_q[2:0]];
              end else if (bit_q == 4'd8) begin
                dat_oe_q <= ~parity_q;
              end else if (bit_q == 4'd9) begin
                dat_oe_q <= 1'b0;
              end
              if (bit_q == 4'd10) begin
                if (dat_sync_q) begin
                  error_q    <= 1'b1;
                  err_code_q <= ERR_NACK;
                  dat_oe_q   <= 1'b0;
                  state_q    <= FAIL;
                end else begin
                  state_q <= WAIT_IDLE;
                end
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
          end
        end
        WAIT_IDLE: begin
          // done is raised here and held one cycle so cmd_ready follows the pulse
          if (done_q) begin
            state_q <= IDLE;
          end else if (tmo_q == TMO_LAST) begin
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= FAIL;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (clk_sync && dat_sync_q) begin
              done_q <= 1'b1;
            end
          end
        end
        FAIL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = done_q;
  assign error      = error_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for the PS/2 host transmitter
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int RQ  = 10;
  localparam int TMO = 1500;

  localparam int M_ACK    = 0;
  localparam int M_NACK   = 1;
  localparam int M_SILENT = 2;
  localparam int M_ABORT  = 3;

  typedef struct {
    bit       is_err;
    bit [1:0] code;
    bit [7:0] b;
    bit       has_frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
  logic [1:0] err_code;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       line_clk, line_dat;

  assign line_clk = ~(ps2_clk_oe | dev_clk_low);
  assign line_dat = ~(ps2_dat_oe | dev_dat_low);

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int last_pulse_cyc = 0;
  int dev_falls = 0;
  bit dev_active = 1'b0;

  exp_t       exp_q[$];
  logic [9:0] cap_q[$];
  int         mode_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (RQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (line_clk),
    .ps2_dat_in (line_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports a completion
  bit   after_pend = 1'b0;
  exp_t after_exp;
  always @(negedge clk) begin
    exp_t e;
    logic [9:0] f;
    if (after_pend) begin
      after_pend = 1'b0;
      chk("pulse_width", {30'b0, done, error}, 32'd0);
      chk("ready_after_pulse", cmd_ready, 1);
      chk("err_code_held", err_code, after_exp.code);
    end
    if (resetn && (done || error)) begin
      last_pulse_cyc = cyc;
      chk("pulse_exclusive", done & error, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual done=%0b error=%0b expected none", done, error);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", error, e.is_err);
        chk("err_code", err_code, e.code);
        if (e.is_err) chk("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
        if (e.code == ERR_TIMEOUT) chk("timeout_latency", cyc - rel_cyc, TMO);
        if (e.has_frame) begin
          if (cap_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_missing actual none expected byte %0h", e.b);
          end else begin
            f = cap_q.pop_front();
            chk("frame_data", f[7:0], e.b);
            chk("frame_parity", f[8], ($countones(e.b) % 2 == 0) ? 1 : 0);
            chk("frame_stop", f[9], 1);
          end
        end
        after_pend = 1'b1;
        after_exp  = e;
      end
    end
  end

  // Device model: answers each request-to-send with 10 clocked bits plus the ACK clock
  initial begin
    int mode;
    int h;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (resetn && busy && !ps2_clk_oe && ps2_dat_oe) begin
        mode = (mode_q.size() != 0) ? mode_q.pop_front() : M_ACK;
        dev_active = 1'b1;
        if (mode == M_SILENT) begin
          for (int k = 0; k < TMO + 100 && busy; k++) @(negedge clk);
        end else begin
          h = $urandom_range(8, 25);
          repeat ($urandom_range(5, 20)) @(negedge clk);
          for (int p = 0; p < 10; p++) begin
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (h) @(negedge clk);
            bits[p] = line_dat;
            dev_clk_low = 1'b0;
            repeat (h) @(negedge clk);
          end
          if (mode != M_ABORT) cap_q.push_back(bits);
          if (mode == M_ACK) dev_dat_low = 1'b1;
          repeat (4) @(negedge clk);
          dev_clk_low = 1'b1;
          dev_falls++;
          repeat (h) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (2) @(negedge clk);
          dev_dat_low = 1'b0;
        end
        dev_active = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] b, input int mode, input bit hold,
                      input logic [7:0] next_b, input bit b2b);
    exp_t e;
    int   j;
    e.b         = b;
    e.has_frame = (mode == M_ACK || mode == M_NACK);
    e.is_err    = (mode != M_ACK);
    e.code      = (mode == M_NACK) ? ERR_NACK : (mode == M_SILENT) ? ERR_TIMEOUT : ERR_NONE;
    if (mode != M_ABORT) exp_q.push_back(e);
    mode_q.push_back(mode);
    @(negedge clk);
    cmd_data  = b;
    cmd_valid = 1'b1;
    j = 0;
    while (!cmd_ready && j < 20000) begin
      @(negedge clk);
      j++;
    end
    if (!cmd_ready) begin
      chk("ready_wait", cmd_ready, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (b2b) chk("b2b_accept_cycle", cyc - last_pulse_cyc, 2);
    chk("hs_busy", busy, 1);
    chk("hs_ready_low", cmd_ready, 0);
    chk("hs_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b10);
    chk("hs_err_cleared", err_code, ERR_NONE);
    if (hold) cmd_data = next_b;
    else cmd_valid = 1'b0;
    j = 0;
    while (!ps2_dat_oe && j < INH + 50) begin
      @(negedge clk);
      j++;
    end
    chk("inhibit_len", j, INH);
    j = 0;
    while (ps2_clk_oe && j < RQ + 50) begin
      @(negedge clk);
      j++;
    end
    chk("req_len", j, RQ);
    rel_cyc = cyc;
  endtask

  task automatic wait_idle();
    int j;
    j = 0;
    while ((busy || dev_active || exp_q.size() != 0) && j < 20000) begin
      @(negedge clk);
      j++;
    end
    chk("idle_wait", {busy, dev_active}, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int j;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_flags", {busy, done, error, ps2_clk_oe, ps2_dat_oe}, 0);
    chk("rst_err_code", err_code, ERR_NONE);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);

    send(CMD_SET_LEDS, M_ACK, 1'b0, 8'h00, 1'b0);
    wait_idle();
    send(CMD_ENABLE, M_ACK, 1'b0, 8'h00, 1'b0);
    wait_idle();
    send(CMD_RESET, M_NACK, 1'b0, 8'h00, 1'b0);
    wait_idle();
    send(8'($urandom), M_SILENT, 1'b0, 8'h00, 1'b0);
    wait_idle();

    send(CMD_SET_LEDS, M_ACK, 1'b1, 8'h12, 1'b0);
    send(8'h12, M_ACK, 1'b0, 8'h00, 1'b1);
    wait_idle();

    base = dev_falls;
    send(8'($urandom), M_ABORT, 1'b0, 8'h00, 1'b0);
    j = 0;
    while (dev_falls < base + 5 && j < 5000) begin
      @(negedge clk);
      j++;
    end
    chk("abort_reached_bit4", dev_falls - base, 5);
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("async_rst_flags", {busy, done, error}, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_err_code", err_code, ERR_NONE);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0) ? M_NACK : M_ACK, 1'b0, 8'h00, 1'b0);
      wait_idle();
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("frames_consumed", cap_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog actual still running expected finished (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
